// File: rtl/risc16_mc_core_if.sv
// Memory bus bundle for the RiSC-16 multi-cycle core: one instruction-fetch
// channel and one data channel, each a level request held until acknowledge.
// The master modport faces the core, the slave modport faces the memories.
interface risc16_mc_core_if #(
    parameter int IMEM_AW = 16,
    parameter int DMEM_AW = 16
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [15:0]        imem_rdata;
    logic               imem_ack;

    logic               dmem_req;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [15:0]        dmem_wdata;
    logic [15:0]        dmem_rdata;
    logic               dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/risc16_mc_core.sv
// RiSC-16 multi-cycle core: BOOT -> FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Every bus output and the retire pulse come straight from flops.
// Optional feature: define RISC16_HALT_EN to make JALR r0,r0,<nonzero simm7>
// stop the core in HALT with halted=1 until reset; otherwise halted is 0.
module risc16_mc_core #(
    parameter int          IMEM_AW  = 16,
    parameter int          DMEM_AW  = 16,
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic             clk,
    input  logic             rst,
    risc16_mc_core_if.master bus,
    output logic             retire,
    output logic             halted
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    typedef enum logic [2:0] {
        ST_BOOT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    state_t state_r, next_state_s;

    logic               armed_r;
    logic [15:0]        pc_r, ir_r, a_val_r, b_val_r, c_val_r, result_r, next_pc_r;
    logic [15:0]        rf_r [0:7];
    logic               imem_req_r, dmem_req_r, dmem_we_r, retire_r;
    logic [IMEM_AW-1:0] imem_addr_r;
    logic [DMEM_AW-1:0] dmem_addr_r;
    logic [15:0]        dmem_wdata_r;

    // Instruction fields and derived decode
    logic [2:0]  op_s, ra_s, rb_s, rc_s;
    logic [15:0] simm_s, pc_inc_s, fetch_pc_s;
    logic [9:0]  imm10_s;
    logic        is_mem_s, writes_ra_s, halt_hit_s;
    logic [15:0] exec_result_s, exec_next_pc_s, exec_ea_s;

    // r0 always reads as zero regardless of storage contents
    function automatic logic [15:0] rf_read(input logic [2:0] idx, input logic [15:0] val);
        rf_read = (idx == 3'd0) ? 16'd0 : val;
    endfunction

    assign op_s        = ir_r[15:13];
    assign ra_s        = ir_r[12:10];
    assign rb_s        = ir_r[9:7];
    assign rc_s        = ir_r[2:0];
    assign imm10_s     = ir_r[9:0];
    assign simm_s      = {{9{ir_r[6]}}, ir_r[6:0]};
    assign pc_inc_s    = pc_r + 16'd1;
    assign is_mem_s    = (op_s == OP_SW) || (op_s == OP_LW);
    assign writes_ra_s = (op_s != OP_SW) && (op_s != OP_BEQ);
    // WB updates pc on the same edge that launches the next fetch
    assign fetch_pc_s  = (state_r == ST_WB) ? next_pc_r : pc_r;

`ifdef RISC16_HALT_EN
    logic halted_r;
    assign halt_hit_s = (op_s == OP_JALR) && (ra_s == 3'd0) && (rb_s == 3'd0) &&
                        (ir_r[6:0] != 7'd0);
    assign halted     = halted_r;

    // Sticky halt flag, raised as WB hands over to HALT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_r <= 1'b0;
        end else if (next_state_s == ST_HALT) begin
            halted_r <= 1'b1;
        end
    end
`else
    assign halt_hit_s = 1'b0;
    assign halted     = 1'b0;
`endif

    assign retire         = retire_r;
    assign bus.imem_req   = imem_req_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.dmem_req   = dmem_req_r;
    assign bus.dmem_we    = dmem_we_r;
    assign bus.dmem_addr  = dmem_addr_r;
    assign bus.dmem_wdata = dmem_wdata_r;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; acks only matter in the state that owns the request
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_BOOT:   if (armed_r) next_state_s = ST_FETCH; else next_state_s = ST_BOOT;
            ST_FETCH:  if (bus.imem_ack) next_state_s = ST_DECODE; else next_state_s = ST_FETCH;
            ST_DECODE: next_state_s = ST_EXEC;
            ST_EXEC:   if (is_mem_s) next_state_s = ST_MEM; else next_state_s = ST_WB;
            ST_MEM:    if (bus.dmem_ack) next_state_s = ST_WB; else next_state_s = ST_MEM;
            ST_WB:     if (halt_hit_s) next_state_s = ST_HALT; else next_state_s = ST_FETCH;
            ST_HALT:   next_state_s = ST_HALT;
            default:   next_state_s = ST_BOOT;
        endcase
    end

    // ALU, effective address and next-PC computation for the EXEC cycle
    always_comb begin
        exec_result_s  = 16'd0;
        exec_next_pc_s = pc_inc_s;
        exec_ea_s      = b_val_r + simm_s;
        case (op_s)
            OP_ADD:  exec_result_s = b_val_r + c_val_r;
            OP_ADDI: exec_result_s = b_val_r + simm_s;
            OP_NAND: exec_result_s = ~(b_val_r & c_val_r);
            OP_LUI:  exec_result_s = {imm10_s, 6'b000000};
            OP_SW:   exec_result_s = 16'd0;
            OP_LW:   exec_result_s = 16'd0;
            OP_BEQ: begin
                if (a_val_r == b_val_r) exec_next_pc_s = pc_inc_s + simm_s;
                else                    exec_next_pc_s = pc_inc_s;
            end
            OP_JALR: begin
                exec_result_s  = pc_inc_s;
                exec_next_pc_s = b_val_r;
            end
            default: exec_result_s = 16'd0;
        endcase
    end

    // Datapath, register file and registered bus outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_r      <= 1'b0;
            pc_r         <= RESET_PC;
            ir_r         <= 16'd0;
            a_val_r      <= 16'd0;
            b_val_r      <= 16'd0;
            c_val_r      <= 16'd0;
            result_r     <= 16'd0;
            next_pc_r    <= 16'd0;
            for (int i = 0; i < 8; i++) rf_r[i] <= 16'd0;
            imem_req_r   <= 1'b0;
            imem_addr_r  <= {IMEM_AW{1'b0}};
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= {DMEM_AW{1'b0}};
            dmem_wdata_r <= 16'd0;
            retire_r     <= 1'b0;
        end else begin
            // The first edge after reset release only arms the core; BOOT
            // then occupies one full cycle before the first fetch.
            armed_r    <= 1'b1;
            retire_r   <= (state_r == ST_WB);
            imem_req_r <= (next_state_s == ST_FETCH);
            if ((next_state_s == ST_FETCH) && (state_r != ST_FETCH)) begin
                imem_addr_r <= fetch_pc_s[IMEM_AW-1:0];
            end
            case (state_r)
                ST_FETCH: begin
                    if (bus.imem_ack) ir_r <= bus.imem_rdata;
                end
                ST_DECODE: begin
                    a_val_r <= rf_read(ra_s, rf_r[ra_s]);
                    b_val_r <= rf_read(rb_s, rf_r[rb_s]);
                    c_val_r <= rf_read(rc_s, rf_r[rc_s]);
                end
                ST_EXEC: begin
                    result_r  <= exec_result_s;
                    next_pc_r <= exec_next_pc_s;
                    if (is_mem_s) begin
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= (op_s == OP_SW);
                        dmem_addr_r  <= exec_ea_s[DMEM_AW-1:0];
                        dmem_wdata_r <= (op_s == OP_SW) ? a_val_r : 16'd0;
                    end
                end
                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        if (!dmem_we_r) result_r <= bus.dmem_rdata;
                    end
                end
                ST_WB: begin
                    if (writes_ra_s && (ra_s != 3'd0)) rf_r[ra_s] <= result_r;
                    pc_r <= next_pc_r;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_risc16_mc_core.sv
// Directed bench for risc16_mc_core: memory models with programmable ack
// wait, hand-assembled programs and hand-computed register/timing values.
module tb_risc16_mc_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic retire, halted;
    int   checks   = 0;
    int   failures = 0;

    risc16_mc_core_if #(.IMEM_AW(16), .DMEM_AW(16)) bus ();

    risc16_mc_core #(.IMEM_AW(16), .DMEM_AW(16), .RESET_PC(16'd0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory models
    logic [15:0] imem [0:63];
    logic [15:0] dmem [0:63];
    int   iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    logic dack_force = 1'b0;
    logic dmem_clr = 1'b0;
    int   dreq_cycles = 0, st_cnt = 0;
    logic [15:0] st_addr = 16'd0, st_wdata = 16'd0;

    assign bus.imem_ack   = bus.imem_req && (icnt >= iwait);
    assign bus.imem_rdata = imem[bus.imem_addr[5:0]];
    assign bus.dmem_ack   = (bus.dmem_req && (dcnt >= dwait)) || dack_force;
    assign bus.dmem_rdata = dmem[bus.dmem_addr[5:0]];

    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) icnt <= icnt + 1; else icnt <= 0;
        if (bus.dmem_req && !bus.dmem_ack) dcnt <= dcnt + 1; else dcnt <= 0;
        if (bus.dmem_req) dreq_cycles <= dreq_cycles + 1;
        if (dmem_clr) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 16'd0;
        end else if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
            dmem[bus.dmem_addr[5:0]] <= bus.dmem_wdata;
            st_addr  <= bus.dmem_addr;
            st_wdata <= bus.dmem_wdata;
            st_cnt   <= st_cnt + 1;
        end
    end

    function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input int imm);
        logic [31:0] v;
        v = imm;
        return {op, ra, rb, v[6:0]};
    endfunction

    function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [2:0] rc);
        return {op, ra, rb, 4'b0000, rc};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 16'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        dmem_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dmem_clr = 1'b0;
        rst = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next retire pulse; cycles = posedges since the call
    task automatic wait_retire(output int cycles);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (retire === 1'b1) seen = 1'b1;
        end
        cycles = n;
        if (!seen) begin
            checks++; failures++;
            $display("FAIL retire_timeout: no retire within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        clear_imem();
        iwait = 0; dwait = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.imem_req, bus.dmem_req, bus.dmem_we, retire, halted} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.imem_req, bus.dmem_req, bus.dmem_we, retire, halted});
        end
        checks++;
        if ({bus.imem_addr, bus.dmem_addr, bus.dmem_wdata} !== 48'd0) begin
            failures++;
            $display("FAIL reset_bus: got %h want 0", {bus.imem_addr, bus.dmem_addr, bus.dmem_wdata});
        end
        checks++;
        if (dut.pc_r !== 16'd0 || dut.rf_r[7] !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: pc=%h r7=%h want 0 0", dut.pc_r, dut.rf_r[7]);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL boot_no_req: imem_req=%b want 0", bus.imem_req);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'd0) begin
            failures++;
            $display("FAIL first_fetch: req=%b addr=%h want 1 0000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_alu();
        int c;
        clear_imem();
        imem[0] = rri(3'b001, 3'd1, 3'd0, 5);
        imem[1] = rri(3'b001, 3'd2, 3'd0, -3);
        imem[2] = rrr(3'b000, 3'd3, 3'd1, 3'd2);
        imem[3] = {3'b011, 3'd4, 10'h3FF};
        imem[4] = rri(3'b001, 3'd4, 3'd4, 63);
        imem[5] = rrr(3'b010, 3'd5, 3'd4, 3'd4);
        imem[6] = rrr(3'b000, 3'd0, 3'd4, 3'd4) | 16'h0078;
        iwait = 0; dwait = 0;
        do_reset();
        wait_retire(c);
        checks++;
        if (c != 6) begin failures++; $display("FAIL first_retire_lat: got %0d want 6", c); end
        wait_retire(c);
        wait_retire(c);
        checks++;
        if (c != 4) begin failures++; $display("FAIL alu_retire_gap: got %0d want 4", c); end
        checks++;
        if (dut.rf_r[1] !== 16'd5 || dut.rf_r[2] !== 16'hFFFD || dut.rf_r[3] !== 16'd2 || dut.pc_r !== 16'd3) begin
            failures++;
            $display("FAIL add_prog: r1=%h r2=%h r3=%h pc=%h want 0005 fffd 0002 0003",
                     dut.rf_r[1], dut.rf_r[2], dut.rf_r[3], dut.pc_r);
        end
        wait_retire(c);
        checks++;
        if (dut.rf_r[4] !== 16'hFFC0) begin failures++; $display("FAIL lui: r4=%h want ffc0", dut.rf_r[4]); end
        wait_retire(c);
        wait_retire(c);
        wait_retire(c);
        checks++;
        if (dut.rf_r[4] !== 16'hFFFF || dut.rf_r[5] !== 16'd0 || dut.rf_r[0] !== 16'd0 || dut.pc_r !== 16'd7) begin
            failures++;
            $display("FAIL nand_r0: r4=%h r5=%h r0=%h pc=%h want ffff 0000 0000 0007",
                     dut.rf_r[4], dut.rf_r[5], dut.rf_r[0], dut.pc_r);
        end
    endtask

    task automatic test_branch();
        int c;
        logic [15:0] exp_pc [0:9];
        exp_pc = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'h20, 16'h21, 16'd7, 16'd7, 16'd7};
        clear_imem();
        imem[0]  = rri(3'b001, 3'd1, 3'd0, 5);
        imem[1]  = rri(3'b001, 3'd2, 3'd0, -3);
        imem[2]  = rri(3'b001, 3'd3, 3'd0, 32);
        imem[3]  = rri(3'b110, 3'd1, 3'd2, 4);
        imem[4]  = rri(3'b110, 3'd1, 3'd1, 4);
        imem[9]  = rri(3'b111, 3'd7, 3'd3, 0);
        imem[32] = rri(3'b001, 3'd5, 3'd0, 7);
        imem[33] = rri(3'b111, 3'd5, 3'd5, 0);
        imem[7]  = rri(3'b110, 3'd1, 3'd1, -1);
        iwait = 0; dwait = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wait_retire(c);
            checks++;
            if (dut.pc_r !== exp_pc[i]) begin
                failures++;
                $display("FAIL branch_pc[%0d]: got %h want %h", i, dut.pc_r, exp_pc[i]);
            end
            if (i == 5) begin
                checks++;
                if (dut.rf_r[7] !== 16'd10) begin failures++; $display("FAIL jalr_link: r7=%h want 000a", dut.rf_r[7]); end
            end
            if (i == 7) begin
                checks++;
                if (dut.rf_r[5] !== 16'h22) begin failures++; $display("FAIL jalr_same_reg: r5=%h want 0022", dut.rf_r[5]); end
            end
        end
    endtask

    task automatic test_mem();
        int c, d0, s0;
        clear_imem();
        imem[0] = rri(3'b001, 3'd1, 3'd0, 5);
        imem[1] = rri(3'b100, 3'd1, 3'd0, 10);
        imem[2] = rri(3'b101, 3'd6, 3'd0, 10);
        imem[3] = rri(3'b101, 3'd0, 3'd0, 10);
        iwait = 0; dwait = 3;
        do_reset();
        wait_retire(c);
        d0 = dreq_cycles;
        s0 = st_cnt;
        wait_retire(c);
        checks++;
        if (c != 8) begin failures++; $display("FAIL sw_wait_gap: got %0d want 8", c); end
        checks++;
        if (dreq_cycles - d0 != 4) begin failures++; $display("FAIL sw_req_len: got %0d want 4", dreq_cycles - d0); end
        checks++;
        if (st_cnt - s0 != 1 || st_addr !== 16'd10 || st_wdata !== 16'd5 || dmem[10] !== 16'd5) begin
            failures++;
            $display("FAIL sw_data: n=%0d addr=%h wdata=%h mem=%h want 1 000a 0005 0005",
                     st_cnt - s0, st_addr, st_wdata, dmem[10]);
        end
        wait_retire(c);
        checks++;
        if (c != 8 || dut.rf_r[6] !== 16'd5) begin
            failures++;
            $display("FAIL lw_wait: gap=%0d r6=%h want 8 0005", c, dut.rf_r[6]);
        end
        dwait = 0;
        d0 = dreq_cycles;
        wait_retire(c);
        checks++;
        if (c != 5 || dreq_cycles - d0 != 1 || dut.rf_r[0] !== 16'd0) begin
            failures++;
            $display("FAIL lw_r0: gap=%0d reqcyc=%0d r0=%h want 5 1 0000", c, dreq_cycles - d0, dut.rf_r[0]);
        end
    endtask

    task automatic test_fetch_wait();
        int c;
        clear_imem();
        imem[0] = rri(3'b001, 3'd1, 3'd0, 7);
        imem[1] = rri(3'b001, 3'd1, 3'd1, 1);
        iwait = 2; dwait = 0;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'd0) begin
                failures++;
                $display("FAIL fetch_hold[%0d]: req=%b addr=%h want 1 0000", i, bus.imem_req, bus.imem_addr);
            end
        end
        wait_retire(c);
        checks++;
        if (c != 4) begin failures++; $display("FAIL fetch_wait_lat: got %0d want 4", c); end
        wait_retire(c);
        checks++;
        if (c != 6 || dut.rf_r[1] !== 16'd8) begin
            failures++;
            $display("FAIL fetch_wait_gap: gap=%0d r1=%h want 6 0008", c, dut.rf_r[1]);
        end
    endtask

    task automatic test_reset_in_mem();
        int c, n, s0;
        clear_imem();
        imem[0] = rri(3'b001, 3'd1, 3'd0, 5);
        imem[1] = rri(3'b100, 3'd1, 3'd0, 12);
        iwait = 0; dwait = 100;
        do_reset();
        wait_retire(c);
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (bus.dmem_req !== 1'b1) begin failures++; $display("FAIL sw_issue: dmem_req=%b want 1", bus.dmem_req); end
        tick();
        tick();
        s0 = st_cnt;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || dut.rf_r[1] !== 16'd0 || dut.pc_r !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_mem: req=%b we=%b r1=%h pc=%h want 0 0 0000 0000",
                     bus.dmem_req, bus.dmem_we, dut.rf_r[1], dut.pc_r);
        end
        dack_force = 1'b1;
        dwait = 0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'd0) begin
            failures++;
            $display("FAIL refetch: req=%b addr=%h want 1 0000", bus.imem_req, bus.imem_addr);
        end
        wait_retire(c);
        dack_force = 1'b0;
        checks++;
        if (c != 4 || dut.rf_r[1] !== 16'd5 || st_cnt != s0 || dmem[12] !== 16'd0) begin
            failures++;
            $display("FAIL late_ack_ignored: gap=%0d r1=%h stores=%0d mem=%h want 4 0005 0 0000",
                     c, dut.rf_r[1], st_cnt - s0, dmem[12]);
        end
        wait_retire(c);
        checks++;
        if (c != 5 || dmem[12] !== 16'd5) begin
            failures++;
            $display("FAIL sw_after_reset: gap=%0d mem=%h want 5 0005", c, dmem[12]);
        end
    endtask

    task automatic test_halt();
        int c, seen_req, seen_ret;
        clear_imem();
        imem[0] = rri(3'b111, 3'd0, 3'd0, 1);
        iwait = 0; dwait = 0;
        do_reset();
        wait_retire(c);
`ifdef RISC16_HALT_EN
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag: halted=%b want 1", halted); end
        seen_req = 0;
        seen_ret = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.imem_req === 1'b1 || bus.dmem_req === 1'b1) seen_req++;
            if (retire === 1'b1) seen_ret++;
        end
        checks++;
        if (seen_req != 0 || seen_ret != 0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_quiet: req_cycles=%0d retires=%0d halted=%b want 0 0 1", seen_req, seen_ret, halted);
        end
`else
        seen_req = 0;
        seen_ret = 0;
        checks++;
        if (halted !== 1'b0 || dut.pc_r !== 16'd0) begin
            failures++;
            $display("FAIL jalr_r0: halted=%b pc=%h want 0 0000", halted, dut.pc_r);
        end
        wait_retire(c);
        checks++;
        if (c != 4 || halted !== 1'b0 || seen_req != seen_ret) begin
            failures++;
            $display("FAIL jalr_r0_loop: gap=%0d halted=%b want 4 0", c, halted);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_fetch_wait();
        test_reset_in_mem();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
